// File: rtl/mem_stage.sv
// mem_stage: RISC-V memory-access stage feeding writeback; ALU ops pass through, loads/stores go to the D-cache.
// Latency: ALU op 1 edge after accept; load >= 3 edges (accept, request handshake, response); store 2 edges to next accept.
// Backpressure: in_ready only in IDLE; request held on dc_req_* until dc_req_ready; WAIT/DRAIN stall until dc_resp_valid.
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready + alures_in, stdata_in, is_load, is_store, size_in, unsigned_in, rd_in, pc_in, is_ecall_in : upstream
//   flush                                          : squash whatever is in this stage
//   dc_req_valid/dc_req_ready + dc_req_we/addr/wdata/size : cache request channel
//   dc_resp_valid, dc_resp_data                    : aligned doubleword load response
//   lddata_out, alures_out, ld_or_alu, rd_mem, curr_pc, is_ecall : writeback (rd_mem == 0 is a bubble)
//   misalign_err, misalign_addr                    : misalignment trap report
//
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned loads/stores instead of issuing them.
module mem_stage #(
    parameter int REGBITS = 5,
    parameter int LOGSIZE = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LOGSIZE-1:0] alures_in,
    input  logic [LOGSIZE-1:0] stdata_in,
    input  logic               is_load,
    input  logic               is_store,
    input  logic [1:0]         size_in,
    input  logic               unsigned_in,
    input  logic [REGBITS-1:0] rd_in,
    input  logic [31:0]        pc_in,
    input  logic               is_ecall_in,
    input  logic               flush,
    output logic               dc_req_valid,
    input  logic               dc_req_ready,
    output logic               dc_req_we,
    output logic [LOGSIZE-1:0] dc_req_addr,
    output logic [LOGSIZE-1:0] dc_req_wdata,
    output logic [1:0]         dc_req_size,
    input  logic               dc_resp_valid,
    input  logic [LOGSIZE-1:0] dc_resp_data,
    output logic [LOGSIZE-1:0] lddata_out,
    output logic [LOGSIZE-1:0] alures_out,
    output logic               ld_or_alu,
    output logic [REGBITS-1:0] rd_mem,
    output logic [31:0]        curr_pc,
    output logic               is_ecall,
    output logic               misalign_err,
    output logic [LOGSIZE-1:0] misalign_addr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t state, state_nxt;

    // Captured attributes of the memory op in flight (address/size/we live in dc_req_*).
    logic               op_unsigned;
    logic [REGBITS-1:0] op_rd;
    logic [31:0]        op_pc;
    logic               op_ecall;

    logic accept;
    logic mem_op;
    logic issue;

    assign mem_op = is_load | is_store;
    assign accept = in_valid & in_ready & ~flush;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (size_in)
            2'd1:    misaligned = alures_in[0];
            2'd2:    misaligned = |alures_in[1:0];
            2'd3:    misaligned = |alures_in[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign issue = accept & mem_op & ~misaligned;
`else
    assign issue = accept & mem_op;
`endif

    // Load extraction: bring the addressed byte lane down to bit 0, then extend by size.
    logic [5:0]         shamt;
    logic [LOGSIZE-1:0] shifted;
    logic [LOGSIZE-1:0] ld_ext;

    assign shamt   = {dc_req_addr[2:0], 3'b000};
    assign shifted = dc_resp_data >> shamt;

    always_comb begin
        ld_ext = shifted;
        case (dc_req_size)
            2'd0: ld_ext = op_unsigned ? {{(LOGSIZE-8){1'b0}}, shifted[7:0]}
                                       : {{(LOGSIZE-8){shifted[7]}}, shifted[7:0]};
            2'd1: ld_ext = op_unsigned ? {{(LOGSIZE-16){1'b0}}, shifted[15:0]}
                                       : {{(LOGSIZE-16){shifted[15]}}, shifted[15:0]};
            2'd2: ld_ext = op_unsigned ? {{(LOGSIZE-32){1'b0}}, shifted[31:0]}
                                       : {{(LOGSIZE-32){shifted[31]}}, shifted[31:0]};
            default: ld_ext = shifted;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // Flush beats a coincident ready: the request counts as never sent.
                if (flush) begin
                    state_nxt = IDLE;
                end else if (dc_req_ready) begin
                    state_nxt = dc_req_we ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (dc_resp_valid) begin
                    state_nxt = IDLE;
                end else if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (dc_resp_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // dc_req_valid is gated by flush so the cache never sees a handshake on a squashed request.
    always_comb begin
        in_ready     = (state == IDLE) && rst;
        dc_req_valid = (state == REQ) && !flush;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dc_req_we    <= 1'b0;
            dc_req_addr  <= '0;
            dc_req_wdata <= '0;
            dc_req_size  <= 2'd0;
            op_unsigned  <= 1'b0;
            op_rd        <= '0;
            op_pc        <= '0;
            op_ecall     <= 1'b0;
            lddata_out   <= '0;
            alures_out   <= '0;
            ld_or_alu    <= 1'b0;
            rd_mem       <= '0;
            curr_pc      <= '0;
            is_ecall     <= 1'b0;
        end else begin
            // Bubble unless something completes this edge.
            rd_mem <= '0;

            if (accept && !mem_op) begin
                rd_mem     <= rd_in;
                alures_out <= alures_in;
                ld_or_alu  <= 1'b0;
                curr_pc    <= pc_in;
                is_ecall   <= is_ecall_in;
            end

            if (issue) begin
                dc_req_we    <= is_store;
                dc_req_addr  <= alures_in;
                dc_req_wdata <= stdata_in;
                dc_req_size  <= size_in;
                op_unsigned  <= unsigned_in;
                op_rd        <= rd_in;
                op_pc        <= pc_in;
                op_ecall     <= is_ecall_in;
            end

            if (state == WAIT && dc_resp_valid && !flush) begin
                lddata_out <= ld_ext;
                ld_or_alu  <= 1'b1;
                rd_mem     <= op_rd;
                curr_pc    <= op_pc;
                is_ecall   <= op_ecall;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign_err <= 1'b0;
            if (accept && mem_op && misaligned) begin
                misalign_err  <= 1'b1;
                misalign_addr <= alures_in;
            end
        end
    end
`else
    assign misalign_err  = 1'b0;
    assign misalign_addr = '0;
`endif

endmodule
